// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter that sequences
// the select of the shared 8:1 single-bit mux.
//   arb_state_e : FSM state encoding (IDLE, GRANT)
//   N_REQ/SEL_W : requester count and select width
//   pick_t      : result of a round-robin pick (valid flag + winner index)
//   rr_pick     : rotate-and-priority-encode starting just after last_ptr
//   onehot8     : index to one-hot grant vector
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Searches (last_ptr+1), (last_ptr+2), ... with wrap-around. The loop runs
  // from the farthest offset down to the nearest so the nearest set bit is
  // the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] last_ptr);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = last_ptr + SEL_W'(i + 1);
      if (req[idx]) begin
        p.valid = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the eight requesters and the round-robin arbiter.
//   req_i     : per-requester request (bit k = requester k)
//   in_i      : per-requester data bit feeding mux input k
//   gnt_o     : one-hot grant, zero when idle
//   sel_o     : binary index of the granted requester
//               (mux select pins: s0 = sel_o[2], s1 = sel_o[1], s2 = sel_o[0])
//   y_o       : registered mux output
//   y_valid_o : y_o holds data sampled from a granted requester
//   busy_o    : arbiter is in GRANT
//   state_o   : FSM state, for observation only
//
// Handshake: a requester raises req_i[k] and holds it for as long as it wants
// the mux; it owns the mux in every cycle where gnt_o[k] is high and gives it
// up by dropping req_i[k]. The arbiter may also withdraw the grant when the
// hold limit is reached while others wait; the requester simply keeps its
// request up and is served again later. y_o/y_valid_o trail the grant by one
// cycle and carry no back-pressure.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] in_i;
  logic [N_REQ-1:0] gnt_o;
  logic [SEL_W-1:0] sel_o;
  logic             y_o;
  logic             y_valid_o;
  logic             busy_o;
  arb_state_e       state_o;

  modport slave (
    input  req_i, in_i,
    output gnt_o, sel_o, y_o, y_valid_o, busy_o, state_o
  );

  modport master (
    output req_i, in_i,
    input  gnt_o, sel_o, y_o, y_valid_o, busy_o, state_o
  );

endinterface

// File: rtl/rr_priority8.sv
// Combinational round-robin picker for eight candidates.
//   cand_i     : candidate request vector
//   last_ptr_i : index granted most recently; search starts one above it
//   valid_o    : at least one candidate is set
//   idx_o      : index of the winning candidate
module rr_priority8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand_i,
  input  logic [SEL_W-1:0] last_ptr_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] idx_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(cand_i, last_ptr_i);
    valid_o = pick.valid;
    idx_o   = pick.idx;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 8:1 single-bit mux.
// Grants one requester at a time, drives the mux select, registers the
// selected data bit and bounds each tenure with a hold limit.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : requester-side signals (see mux8_rr_arbiter_if)
// Parameters:
//   HOLD_MAX : max consecutive grant cycles while others wait (0 = unlimited)
//   CNT_W    : hold counter width, 2**CNT_W > HOLD_MAX
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input logic              clk,
  input logic              rst_n,
  mux8_rr_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             y_q, y_d;
  logic             yv_q, yv_d;

  logic             rel;
  logic             contenders;
  logic             expire;
  logic [N_REQ-1:0] cand;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  // Candidate selection. On expiry the current holder is masked out so the
  // turn passes on; on release (including a same-cycle drop/raise) the raw
  // request vector is used, which already has the holder's bit clear.
  always_comb begin
    rel        = 1'b0;
    contenders = 1'b0;
    expire     = 1'b0;
    cand       = bus.req_i;
    if (state_q == GRANT) begin
      rel        = !bus.req_i[sel_q];
      contenders = |(bus.req_i & ~gnt_q);
      expire     = (HOLD_MAX != 0) && (hold_q == HOLD_LIM) && contenders;
      if (!rel && expire) begin
        cand = bus.req_i & ~gnt_q;
      end
    end
  end

  rr_priority8 u_pick (
    .cand_i     (cand),
    .last_ptr_i (last_q),
    .valid_o    (pick_valid),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    y_d     = y_q;
    yv_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = onehot8(pick_idx);
          sel_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = CNT_W'(1);
        end else begin
          gnt_d  = '0;
          sel_d  = '0;
          hold_d = '0;
        end
      end

      GRANT: begin
        // Data path trails the grant by one cycle.
        y_d  = bus.in_i[sel_q];
        yv_d = 1'b1;
        if (rel || expire) begin
          if (pick_valid) begin
            gnt_d  = onehot8(pick_idx);
            sel_d  = pick_idx;
            last_d = pick_idx;
            hold_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            hold_d  = '0;
          end
        end else if ((HOLD_MAX != 0) && (hold_q == HOLD_LIM)) begin
          // Limit reached with nobody waiting: start a fresh window.
          hold_d = CNT_W'(1);
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      hold_q  <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.sel_o     = sel_q;
  assign bus.y_o       = y_q;
  assign bus.y_valid_o = yv_q;
  assign bus.busy_o    = (state_q == GRANT);
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter (HOLD_MAX = 4).
module tb_mux8_rr_arbiter;

  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       yv;
    logic       busy;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(
    .HOLD_MAX (4),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  vec_t exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " gnt"},   32'(bus.gnt_o),     32'(v.gnt));
    chk({tag, " sel"},   32'(bus.sel_o),     32'(v.sel));
    chk({tag, " y"},     32'(bus.y_o),       32'(v.y));
    chk({tag, " yv"},    32'(bus.y_valid_o), 32'(v.yv));
    chk({tag, " busy"},  32'(bus.busy_o),    32'(v.busy));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives, waits one edge, then checks.
  task automatic step(input string tag, input vec_t v);
    bus.req_i = v.req;
    bus.in_i  = v.din;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  task automatic push(input logic [7:0] req, input logic [7:0] din, input logic [7:0] gnt,
                      input logic [2:0] sel, input logic y, input logic yv, input logic busy);
    vec_t v;
    v.req = req; v.din = din; v.gnt = gnt; v.sel = sel;
    v.y = y; v.yv = yv; v.busy = busy;
    exp_q.push_back(v);
  endtask

  task automatic run_queue(input string name);
    int n;
    vec_t v;
    n = 0;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      n++;
      step($sformatf("%s[%0d]", name, n), v);
    end
  endtask

  task automatic do_reset(input logic [7:0] req, input logic [7:0] din);
    bus.req_i = req;
    bus.in_i  = din;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] din_v;
    vec_t rv;
    int   g;
    rst_n     = 1'b0;
    bus.req_i = 8'hFF;
    bus.in_i  = 8'hA5;
    #2;
    rv = '{req: 8'hFF, din: 8'hA5, gnt: 8'h00, sel: 3'd0, y: 1'b0, yv: 1'b0, busy: 1'b0};
    check_outs("reset", rv);

    // Full rotation with all requesters: 0..7 then 0, four cycles each.
    din_v = 8'hA5;
    do_reset(8'hFF, din_v);
    for (int n = 1; n <= 33; n++) begin
      g = ((n - 1) / 4) % 8;
      if (n >= 2)
        push(8'hFF, din_v, 8'(1) << g, 3'(g), din_v[((n - 2) / 4) % 8], 1'b1, 1'b1);
      else
        push(8'hFF, din_v, 8'(1) << g, 3'(g), 1'b0, 1'b0, 1'b1);
    end
    run_queue("rot");

    // Lone requester 5: no expiry, then release to IDLE.
    do_reset(8'h20, 8'h20);
    push(8'h20, 8'h20, 8'h20, 3'd5, 1'b0, 1'b0, 1'b1);
    for (int n = 2; n <= 10; n++)
      push(8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
    push(8'h00, 8'h20, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0);
    push(8'h00, 8'h20, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    push(8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    run_queue("solo5");

    // Data path: requester 3 granted, only in_i[3] may move y_o.
    do_reset(8'h08, 8'h08);
    push(8'h08, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0, 1'b1);
    push(8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
    push(8'h08, 8'h00, 8'h08, 3'd3, 1'b0, 1'b1, 1'b1);
    push(8'h08, 8'hF7, 8'h08, 3'd3, 1'b0, 1'b1, 1'b1);
    push(8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
    push(8'h08, 8'hF8, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
    push(8'h08, 8'h07, 8'h08, 3'd3, 1'b0, 1'b1, 1'b1);
    run_queue("data3");

    // Same-cycle drop of 2 and raise of 6: direct switch, busy stays high.
    do_reset(8'h04, 8'h04);
    push(8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0, 1'b1);
    push(8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);
    push(8'h40, 8'h04, 8'h40, 3'd6, 1'b1, 1'b1, 1'b1);
    push(8'h40, 8'h04, 8'h40, 3'd6, 1'b0, 1'b1, 1'b1);
    run_queue("swap");

    // Asynchronous reset mid-grant (sel_o = 6): clears without a clock edge.
    bus.req_i = 8'h41;
    rst_n = 1'b0;
    #1;
    rv = '{req: 8'h41, din: 8'h04, gnt: 8'h00, sel: 3'd0, y: 1'b0, yv: 1'b0, busy: 1'b0};
    check_outs("async_rst", rv);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(8'h41, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
    push(8'h41, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);
    run_queue("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
